// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// FSM state type, timeout counter width and a funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Stores only accept signed widths; unsigned widths are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension for RV32I loads.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to funct3.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts an ALU effective address plus store data,
// runs a req/ready access to data memory with a bounded wait, and returns
// extended load data with an error flag.
// Optional macro LSU_MISALIGN_TRAP_EN: flag misaligned H/W accesses as
// errors; when undefined, low address bits are dropped to natural alignment.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        eff_lo;
  logic              req_bad;
  logic [31:0]       load_data;

  // Effective lane offset and request error classification.
  always_comb begin
    eff_lo  = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = !f3_legal(req_we, req_funct3)
              || (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    req_bad = !f3_legal(req_we, req_funct3);
    case (req_funct3[1:0])
      2'b00:   eff_lo = req_addr[1:0];
      2'b01:   eff_lo = {req_addr[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase
`endif
  end

  lsu_load_align u_align (
    .word    (mem_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          alo_d = eff_lo;
          cnt_d = '0;
          if (req_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = ST_ACCESS;
            mem_req_d  = 1'b1;
            mem_we_d   = req_we;
            mem_addr_d = {req_addr[31:2], 2'b00};
            case (req_funct3[1:0])
              2'b00: begin
                mem_be_d    = 4'b0001 << eff_lo;
                mem_wdata_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                mem_be_d    = 4'b0011 << eff_lo;
                mem_wdata_d = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = req_wdata;
              end
            endcase
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready on the last permitted cycle still wins over the timeout.
        if (mem_ready) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : load_data;
        end else if (cnt_q + 1'b1 == TO_LIM) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed and randomized accesses against an
// arithmetic reference model of lane selection, extension and timing.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int unsigned n_chk;
  int unsigned n_pass;

  lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; the expected behaviour is derived from byte arithmetic.
  task automatic do_access(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned delay, input logic [31:0] word,
                           output logic [31:0] got);
    int unsigned a, sz, bv, hv, high_cnt, exp_cycles, waited;
    logic        inv, err, timed_out, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, exp_addr;
    inv = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5)));
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a   = addr % 4;
`ifdef LSU_MISALIGN_TRAP_EN
    err = inv || (a % sz != 0);
`else
    err = inv;
    a   = a - a % sz;
`endif
    exp_addr = addr - addr % 4;
    exp_be   = (sz == 1) ? 4'(1 << a) : (sz == 2) ? 4'(3 << a) : 4'd15;
    exp_wd   = (sz == 1) ? (wdata % 256) * 32'h01010101 :
               (sz == 2) ? (wdata % 65536) * 32'h00010001 : wdata;
    bv = (word >> (8 * a)) % 256;
    hv = (word >> (8 * a)) % 65536;
    case (f3)
      3'd0:    exp_rd = (bv >= 128) ? bv - 256 : bv;
      3'd4:    exp_rd = bv;
      3'd1:    exp_rd = (hv >= 32768) ? hv - 65536 : hv;
      3'd5:    exp_rd = hv;
      default: exp_rd = word;
    endcase
    if (we) exp_rd = 32'd0;

    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_wait: got %b want 1", req_ready);
    else n_pass++;

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;

    if (err) begin
      n_chk++;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0)
        $display("FAIL err_resp: mem_req=%b rsp_valid=%b rsp_err=%b rdata=%h want 0 1 1 0",
                 mem_req, rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      got = rsp_rdata;
      step();
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL err_after: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
      else n_pass++;
      return;
    end

    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== exp_addr ||
        mem_be !== exp_be || (we && mem_wdata !== exp_wd) || busy !== 1'b1)
      $display("FAIL mem_drive: req=%b we=%b addr=%h be=%b wd=%h busy=%b want 1 %b %h %b %h 1",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, we, exp_addr, exp_be, exp_wd);
    else n_pass++;

    high_cnt = 0;
    done     = 1'b0;
    for (int c = 0; c < int'(TO) && !done; c++) begin
      if (mem_req === 1'b1) high_cnt++;
      mem_rdata = $urandom;
      if (c == int'(delay)) begin
        mem_ready = 1'b1;
        mem_rdata = word;
        done      = 1'b1;
      end
      step();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    timed_out  = (delay >= TO);
    exp_cycles = timed_out ? TO : delay + 1;

    n_chk++;
    if (high_cnt !== exp_cycles)
      $display("FAIL mem_req_cycles: got %0d want %0d", high_cnt, exp_cycles);
    else n_pass++;

    n_chk++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== timed_out ||
        rsp_rdata !== (timed_out ? 32'd0 : exp_rd))
      $display("FAIL rsp: mem_req=%b valid=%b err=%b rdata=%h want 0 1 %b %h",
               mem_req, rsp_valid, rsp_err, rsp_rdata, timed_out, timed_out ? 32'd0 : exp_rd);
    else n_pass++;
    got = rsp_rdata;

    step();
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== got)
      $display("FAIL rsp_after: valid=%b busy=%b ready=%b rdata=%h want 0 0 1 %h",
               rsp_valid, busy, req_ready, rsp_rdata, got);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;
    step();
    step();
    n_chk++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 ||
        mem_wdata !== 32'd0 || rsp_rdata !== 32'd0)
      $display("FAIL reset_state: ready=%b req=%b we=%b v=%b e=%b busy=%b addr=%h be=%b wd=%h rd=%h want 1 0 0 0 0 0 0 0 0 0",
               req_ready, mem_req, mem_we, rsp_valid, rsp_err, busy, mem_addr, mem_be, mem_wdata, rsp_rdata);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [31:0] got;
    do_access(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, got);
    n_chk++;
    if (got !== 32'hDEADBEEF) $display("FAIL lw_basic: got %h want deadbeef", got);
    else n_pass++;
    do_access(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF1234, got);
    n_chk++;
    if (got !== 32'hFFFFFF80) $display("FAIL lb_sign: got %h want ffffff80", got);
    else n_pass++;
    do_access(1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF1234, got);
    n_chk++;
    if (got !== 32'h00000080) $display("FAIL lbu_zero: got %h want 00000080", got);
    else n_pass++;
    do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'd0, got);
    n_chk++;
    if (got !== 32'd0) $display("FAIL sh_rdata: got %h want 0", got);
    else n_pass++;
    do_access(1'b0, 3'b010, 32'h101, 32'd0, 0, 32'h13579BDF, got);
    n_chk++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (got !== 32'd0) $display("FAIL lw_misaligned: got %h want 0", got);
`else
    if (got !== 32'h13579BDF) $display("FAIL lw_misaligned: got %h want 13579bdf", got);
`endif
    else n_pass++;
    do_access(1'b1, 3'b100, 32'h200, 32'h1, 0, 32'd0, got);
    do_access(1'b0, 3'b011, 32'h200, 32'h0, 0, 32'd0, got);
  endtask

  task automatic test_timeout();
    logic [31:0] got;
    do_access(1'b0, 3'b010, 32'h300, 32'd0, 100, 32'hCAFEF00D, got);
    do_access(1'b0, 3'b001, 32'h302, 32'd0, TO - 1, 32'h8001FFFF, got);
    n_chk++;
    if (got !== 32'hFFFF8001) $display("FAIL ready_last_cycle: got %h want ffff8001", got);
    else n_pass++;
  endtask

  task automatic test_ignore_ready();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      step();
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL idle_ready: valid=%b busy=%b req=%b want 0 0 0", rsp_valid, busy, mem_req);
      else n_pass++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h400;
    step();
    req_valid = 1'b0;
    step();
    n_chk++;
    if (mem_req !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_pre: req=%b busy=%b want 1 1", mem_req, busy);
    else n_pass++;
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mid_async: req=%b busy=%b ready=%b want 0 0 1", mem_req, busy, req_ready);
    else n_pass++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL mid_after: valid=%b req=%b want 0 0", rsp_valid, mem_req);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    logic [2:0]  f3;
    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      do_access(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
                $urandom_range(0, 5), $urandom, got);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_directed();
    test_timeout();
    test_ignore_ready();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the RV32I datapath: it takes the ALU-computed effective address plus store data and access width, drives a request/ready handshake to data memory, and returns sign- or zero-extended load data to writeback. Memory latency is variable, so the unit holds the core via `busy` until the access completes.

## Interface
- `TIMEOUT`, default 255: max cycles waiting for `mem_ready` before abort; 8-bit counter, legal range 1..255.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core requests an access; fields below held stable while `req_valid && !req_ready`.
- `req_ready`  out  1  high only in IDLE; transfer when both are high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- `req_addr`  in  32  effective address (ALU result).
- `req_wdata`  in  32  rs2 value, unshifted.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  store data shifted into lane.
- `mem_ready`  in  1  memory accepts/completes this cycle; `mem_rdata` valid same cycle.
- `mem_rdata`  in  32  read word.
- `rsp_valid`  out  1  one-cycle pulse: access finished.
- `rsp_rdata`  out  32  extended load data (0 for stores/errors).
- `rsp_err`  out  1  with `rsp_valid`: misaligned or timeout.
- `busy`  out  1  state != IDLE; core stall.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on `req_valid`, register all fields. Aligned → ACCESS. Misaligned (H with addr[0]=1, W with addr[1:0]≠0) → RESP with err set, no memory request.
- ACCESS: `mem_req`=1 from registered fields; counter increments each cycle. `mem_ready`=1 → capture extended `mem_rdata` (loads), → RESP. Counter reaches `TIMEOUT` without ready → drop `mem_req`, err set, → RESP.
- RESP: `rsp_valid`=1 for one cycle, → IDLE. Counter cleared.
- Byte enables: B `0001<<addr[1:0]`; H `0011<<addr[1:0]` (addr[1] only); W `1111`. Store data: B replicated to all four lanes, H replicated to both halves, W as-is.
- Load extraction: select byte/half by addr[1:0]; B/H sign-extend from bit 7/15, BU/HU zero-extend, W passthrough.
- Invalid funct3 (011, 11x, or 1xx with store): treated as misaligned error.
- `rsp_rdata` holds value until next RESP.

## Timing
- Reset: state IDLE; `req_ready`=1; `mem_req`, `mem_we`, `rsp_valid`, `rsp_err`, `busy`=0; `mem_addr`, `mem_be`, `mem_wdata`, `rsp_rdata`, counter = 0.
- Accept at edge N; `mem_req` high in cycle N+1; ready in cycle N+1 gives `rsp_valid` in cycle N+2. Minimum latency 2 cycles, zero-wait throughput one access per 3 cycles.
- Error path: accept at N, `rsp_valid`+`rsp_err` in N+1.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles; `mem_ready` coincident with the final cycle counts as success.
- `mem_ready` outside ACCESS ignored.
- Reset mid-access: immediate return to IDLE, `mem_req` drops asynchronously, no response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses flagged as above.
- Undefined: no misalignment check; address low bits dropped to natural alignment (H clears bit 0, W clears bits 1:0) and access proceeds; `rsp_err` only from timeout or invalid funct3.

## Structure
- Package `lsu_pkg`: funct3 encodings, state enum, `TIMEOUT` counter width constant.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension (inputs word, addr[1:0], funct3).

## Test plan
- LW addr 0x100, memory 0xDEADBEEF, ready 1st cycle → `mem_be`=1111, `rsp_rdata`=0xDEADBEEF two cycles after accept.
- LB addr 0x103, word 0x80FF1234 → `rsp_rdata`=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x100.
- LW addr 0x101 with macro → no `mem_req`, `rsp_err`=1 next cycle; without macro → `mem_addr`=0x100, normal load.
- `TIMEOUT`=4, ready never high → `mem_req` high 4 cycles, then `rsp_valid`+`rsp_err`; then next request accepted.
- Reset asserted while in ACCESS → `mem_req`, `busy` drop at once, no `rsp_valid` after release.
